// File: rtl/mcs8_bus_arbiter_if.sv
// Bundle of the fetch/data requester handshakes and the shared memory port.
// master: the arbiter; slave: the requesters and the memory that face it.
interface mcs8_bus_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 8
);
    logic          I_REQ_I;
    logic [AW-1:0] I_ADDR_I;
    logic [DW-1:0] I_DAT_O;
    logic          I_ACK_O;
    logic          I_ERR_O;

    logic          D_REQ_I;
    logic          D_WE_I;
    logic [AW-1:0] D_ADDR_I;
    logic [DW-1:0] D_DAT_I;
    logic [DW-1:0] D_DAT_O;
    logic          D_ACK_O;
    logic          D_ERR_O;

    logic          M_REQ_O;
    logic          M_WE_O;
    logic [AW-1:0] M_ADDR_O;
    logic [DW-1:0] M_DAT_O;
    logic [DW-1:0] M_DAT_I;
    logic          M_ACK_I;

    modport master (
        input  I_REQ_I, I_ADDR_I, D_REQ_I, D_WE_I, D_ADDR_I, D_DAT_I, M_DAT_I, M_ACK_I,
        output I_DAT_O, I_ACK_O, I_ERR_O, D_DAT_O, D_ACK_O, D_ERR_O,
        output M_REQ_O, M_WE_O, M_ADDR_O, M_DAT_O
    );

    modport slave (
        output I_REQ_I, I_ADDR_I, D_REQ_I, D_WE_I, D_ADDR_I, D_DAT_I, M_DAT_I, M_ACK_I,
        input  I_DAT_O, I_ACK_O, I_ERR_O, D_DAT_O, D_ACK_O, D_ERR_O,
        input  M_REQ_O, M_WE_O, M_ADDR_O, M_DAT_O
    );
endinterface

// File: rtl/mcs8_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (I) and data (D)
// requesters, with a bounded wait that returns an error pulse instead of hanging.
module mcs8_bus_arbiter #(
    parameter int AW      = 14,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    mcs8_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    localparam logic          SEL_I = 1'b0;
    localparam logic          SEL_D = 1'b1;
    localparam bit            TO_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] TLIM  = TW'(TIMEOUT - 1);

    state_t        r_state, w_next_state;
    logic          r_last, w_last;
    logic [TW-1:0] r_timer, w_timer;
    logic          r_m_req, w_m_req;
    logic          r_m_we, w_m_we;
    logic [AW-1:0] r_m_addr, w_m_addr;
    logic [DW-1:0] r_m_dat, w_m_dat;
    logic [DW-1:0] r_i_dat, w_i_dat;
    logic [DW-1:0] r_d_dat, w_d_dat;
    logic          r_i_ack, w_i_ack, r_i_err, w_i_err;
    logic          r_d_ack, w_d_ack, r_d_err, w_d_err;
    logic          w_grant_i, w_grant_d;

    // A requester still holding REQ during its own ACK cycle is not a new request.
    wire w_i_elig = bus.I_REQ_I & ~r_i_ack;
    wire w_d_elig = bus.D_REQ_I & ~r_d_ack;
    wire w_busy   = (r_state != ST_IDLE);
    wire w_tmo    = TO_EN && !bus.M_ACK_I && (r_timer == TLIM);
    wire w_end    = w_busy && (bus.M_ACK_I || w_tmo);

    // Next state and grant decision; a finishing transaction hands straight to the other side.
    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_i_elig && w_d_elig) begin
                    if (r_last == SEL_D) w_grant_i = 1'b1;
                    else                 w_grant_d = 1'b1;
                end else if (w_i_elig) begin
                    w_grant_i = 1'b1;
                end else if (w_d_elig) begin
                    w_grant_d = 1'b1;
                end else begin
                    w_grant_i = 1'b0;
                end
                w_next_state = w_grant_i ? ST_BUSY_I : (w_grant_d ? ST_BUSY_D : ST_IDLE);
            end
            ST_BUSY_I: begin
                if (w_end) begin
                    w_grant_d    = w_d_elig;
                    w_next_state = w_d_elig ? ST_BUSY_D : ST_IDLE;
                end else begin
                    w_next_state = ST_BUSY_I;
                end
            end
            ST_BUSY_D: begin
                if (w_end) begin
                    w_grant_i    = w_i_elig;
                    w_next_state = w_i_elig ? ST_BUSY_I : ST_IDLE;
                end else begin
                    w_next_state = ST_BUSY_D;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, timer and round-robin pointer.
    always_comb begin
        w_m_req  = r_m_req;
        w_m_we   = r_m_we;
        w_m_addr = r_m_addr;
        w_m_dat  = r_m_dat;
        w_i_dat  = r_i_dat;
        w_d_dat  = r_d_dat;
        w_i_ack  = 1'b0;
        w_i_err  = 1'b0;
        w_d_ack  = 1'b0;
        w_d_err  = 1'b0;
        w_last   = r_last;
        w_timer  = r_timer;
        if (w_end) begin
            w_m_req = 1'b0;
            if (r_state == ST_BUSY_I) begin
                w_i_ack = 1'b1;
                w_i_err = w_tmo;
                w_i_dat = w_tmo ? {DW{1'b1}} : bus.M_DAT_I;
            end else begin
                w_d_ack = 1'b1;
                w_d_err = w_tmo;
                if (w_tmo)        w_d_dat = {DW{1'b1}};
                else if (!r_m_we) w_d_dat = bus.M_DAT_I;
                else              w_d_dat = r_d_dat;
            end
        end else if (w_busy && TO_EN) begin
            w_timer = r_timer + TW'(1);
        end else begin
            w_timer = r_timer;
        end
        if (w_grant_i) begin
            w_m_req  = 1'b1;
            w_m_we   = 1'b0;
            w_m_addr = bus.I_ADDR_I;
            w_last   = SEL_I;
            w_timer  = '0;
        end else if (w_grant_d) begin
            w_m_req  = 1'b1;
            w_m_we   = bus.D_WE_I;
            w_m_addr = bus.D_ADDR_I;
            w_m_dat  = bus.D_DAT_I;
            w_last   = SEL_D;
            w_timer  = '0;
        end else begin
            w_last   = w_last;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state  <= ST_IDLE;
            r_last   <= SEL_D;
            r_timer  <= '0;
            r_m_req  <= 1'b0;
            r_m_we   <= 1'b0;
            r_m_addr <= '0;
            r_m_dat  <= '0;
            r_i_dat  <= '0;
            r_d_dat  <= '0;
            r_i_ack  <= 1'b0;
            r_i_err  <= 1'b0;
            r_d_ack  <= 1'b0;
            r_d_err  <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_last   <= w_last;
            r_timer  <= w_timer;
            r_m_req  <= w_m_req;
            r_m_we   <= w_m_we;
            r_m_addr <= w_m_addr;
            r_m_dat  <= w_m_dat;
            r_i_dat  <= w_i_dat;
            r_d_dat  <= w_d_dat;
            r_i_ack  <= w_i_ack;
            r_i_err  <= w_i_err;
            r_d_ack  <= w_d_ack;
            r_d_err  <= w_d_err;
        end
    end

    assign bus.M_REQ_O  = r_m_req;
    assign bus.M_WE_O   = r_m_we;
    assign bus.M_ADDR_O = r_m_addr;
    assign bus.M_DAT_O  = r_m_dat;
    assign bus.I_DAT_O  = r_i_dat;
    assign bus.I_ACK_O  = r_i_ack;
    assign bus.I_ERR_O  = r_i_err;
    assign bus.D_DAT_O  = r_d_dat;
    assign bus.D_ACK_O  = r_d_ack;
    assign bus.D_ERR_O  = r_d_err;
endmodule

// File: tb/tb_mcs8_bus_arbiter.sv
// Directed bench for mcs8_bus_arbiter: reset, single accesses, contention,
// timeout and the timeout boundary, all against hand-computed values.
module tb_mcs8_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    mcs8_bus_arbiter_if #(.AW(14), .DW(8)) bus ();

    mcs8_bus_arbiter #(.AW(14), .DW(8), .TIMEOUT(15), .TW(4)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " m_req"},  32'(bus.M_REQ_O),  32'd0);
        check_val({tag, " m_we"},   32'(bus.M_WE_O),   32'd0);
        check_val({tag, " m_addr"}, 32'(bus.M_ADDR_O), 32'd0);
        check_val({tag, " m_dat"},  32'(bus.M_DAT_O),  32'd0);
        check_val({tag, " i_dat"},  32'(bus.I_DAT_O),  32'd0);
        check_val({tag, " d_dat"},  32'(bus.D_DAT_O),  32'd0);
        check_val({tag, " acks"},   32'({bus.I_ACK_O, bus.I_ERR_O, bus.D_ACK_O, bus.D_ERR_O}), 32'd0);
    endtask

    initial begin
        int acks;
        int seq [6];
        int cnt;
        bus.I_REQ_I = 1'b0; bus.I_ADDR_I = 14'h0;
        bus.D_REQ_I = 1'b0; bus.D_WE_I = 1'b0; bus.D_ADDR_I = 14'h0; bus.D_DAT_I = 8'h0;
        bus.M_DAT_I = 8'h0; bus.M_ACK_I = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single I read, zero wait (M_ACK_I high while idle is ignored)
        bus.I_REQ_I = 1'b1; bus.I_ADDR_I = 14'h0123; bus.M_DAT_I = 8'h5A; bus.M_ACK_I = 1'b1;
        tick();
        check_val("i_rd m_req",  32'(bus.M_REQ_O),  32'd1);
        check_val("i_rd m_addr", 32'(bus.M_ADDR_O), 32'h0123);
        check_val("i_rd m_we",   32'(bus.M_WE_O),   32'd0);
        check_val("i_rd early ack", 32'(bus.I_ACK_O), 32'd0);
        tick();
        check_val("i_rd ack",   32'(bus.I_ACK_O), 32'd1);
        check_val("i_rd err",   32'(bus.I_ERR_O), 32'd0);
        check_val("i_rd dat",   32'(bus.I_DAT_O), 32'h5A);
        check_val("i_rd m_req done", 32'(bus.M_REQ_O), 32'd0);
        bus.I_REQ_I = 1'b0; bus.M_ACK_I = 1'b0; bus.M_DAT_I = 8'h00;
        tick();
        check_val("i_rd ack pulse", 32'(bus.I_ACK_O), 32'd0);
        check_val("i_rd dat held",  32'(bus.I_DAT_O), 32'h5A);

        // D write, 3 wait states
        bus.D_REQ_I = 1'b1; bus.D_WE_I = 1'b1; bus.D_ADDR_I = 14'h3FFF; bus.D_DAT_I = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) begin
                bus.D_ADDR_I = 14'h0001; bus.D_DAT_I = 8'h00; bus.D_WE_I = 1'b0;
            end
            check_val("d_wr m_req",  32'(bus.M_REQ_O),  32'd1);
            check_val("d_wr m_we",   32'(bus.M_WE_O),   32'd1);
            check_val("d_wr m_dat",  32'(bus.M_DAT_O),  32'hC3);
            check_val("d_wr m_addr", 32'(bus.M_ADDR_O), 32'h3FFF);
            check_val("d_wr no ack", 32'(bus.D_ACK_O),  32'd0);
        end
        bus.M_ACK_I = 1'b1; bus.M_DAT_I = 8'h77;
        tick();
        check_val("d_wr ack",   32'(bus.D_ACK_O), 32'd1);
        check_val("d_wr err",   32'(bus.D_ERR_O), 32'd0);
        check_val("d_wr m_req", 32'(bus.M_REQ_O), 32'd0);
        check_val("d_wr d_dat unchanged", 32'(bus.D_DAT_O), 32'h00);
        bus.D_REQ_I = 1'b0; bus.M_ACK_I = 1'b0; bus.D_WE_I = 1'b0;
        tick();

        // Contention: both hold REQ, zero wait; last grant was D so I leads
        bus.I_REQ_I = 1'b1; bus.I_ADDR_I = 14'h0AAA;
        bus.D_REQ_I = 1'b1; bus.D_ADDR_I = 14'h1555;
        bus.M_ACK_I = 1'b1; bus.M_DAT_I = 8'h3C;
        acks = 0;
        for (int c = 0; c < 30 && acks < 6; c++) begin
            tick();
            if (bus.I_ACK_O || bus.D_ACK_O) begin
                seq[acks] = bus.D_ACK_O ? 1 : 0;
                if (bus.I_ACK_O) begin
                    check_val("cont handoff m_req",  32'(bus.M_REQ_O),  32'd1);
                    check_val("cont handoff m_addr", 32'(bus.M_ADDR_O), 32'h1555);
                end
                acks++;
            end
        end
        bus.I_REQ_I = 1'b0; bus.D_REQ_I = 1'b0; bus.M_ACK_I = 1'b0;
        check_val("cont ack count", 32'(acks), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < acks) check_val("cont order", 32'(seq[k]), 32'(k % 2));
        end
        tick(); tick();

        // Timeout on a D read
        bus.D_REQ_I = 1'b1; bus.D_WE_I = 1'b0; bus.D_ADDR_I = 14'h0042; bus.M_DAT_I = 8'h24;
        tick();
        check_val("tmo m_req", 32'(bus.M_REQ_O), 32'd1);
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.D_ACK_O || bus.D_ERR_O) cnt++;
        end
        check_val("tmo early ack", 32'(cnt), 32'd0);
        tick();
        check_val("tmo ack",   32'(bus.D_ACK_O), 32'd1);
        check_val("tmo err",   32'(bus.D_ERR_O), 32'd1);
        check_val("tmo dat",   32'(bus.D_DAT_O), 32'hFF);
        check_val("tmo m_req", 32'(bus.M_REQ_O), 32'd0);
        bus.D_REQ_I = 1'b0;
        tick();
        check_val("tmo pulse", 32'({bus.D_ACK_O, bus.D_ERR_O}), 32'd0);

        // Next request served normally
        bus.I_REQ_I = 1'b1; bus.I_ADDR_I = 14'h0200; bus.M_ACK_I = 1'b1; bus.M_DAT_I = 8'h96;
        tick();
        check_val("post m_addr", 32'(bus.M_ADDR_O), 32'h0200);
        tick();
        check_val("post ack", 32'(bus.I_ACK_O), 32'd1);
        check_val("post err", 32'(bus.I_ERR_O), 32'd0);
        check_val("post dat", 32'(bus.I_DAT_O), 32'h96);
        bus.I_REQ_I = 1'b0; bus.M_ACK_I = 1'b0;
        tick();

        // Timeout boundary: M_ACK_I arrives on the limit edge
        bus.I_REQ_I = 1'b1; bus.I_ADDR_I = 14'h0300; bus.M_DAT_I = 8'h11;
        tick();
        for (int i = 0; i < 14; i++) tick();
        bus.M_ACK_I = 1'b1;
        tick();
        check_val("bnd ack", 32'(bus.I_ACK_O), 32'd1);
        check_val("bnd err", 32'(bus.I_ERR_O), 32'd0);
        check_val("bnd dat", 32'(bus.I_DAT_O), 32'h11);
        bus.I_REQ_I = 1'b0; bus.M_ACK_I = 1'b0;
        tick();

        // Reset mid-transaction
        bus.D_REQ_I = 1'b1; bus.D_WE_I = 1'b0; bus.D_ADDR_I = 14'h0777;
        tick();
        check_val("rst pre m_req", 32'(bus.M_REQ_O), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst mid");
        tick();
        rst = 1'b0; bus.D_REQ_I = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.D_ACK_O) cnt++;
        end
        check_val("rst no ack", 32'(cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
